// File: rtl/percept_mac.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | percept_mac : N_IN-input perceptron, one signed MAC per accepted beat,   |
// |               saturated result on valid/ready. Optional PERCEPT_RELU_EN. |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module percept_mac #(
  parameter  int N_IN   = 4,
  parameter  int DATA_W = 8,
  parameter  int OUT_W  = 16,
  localparam int ADDR_W = $clog2(N_IN + 1),
  localparam int ACC_W  = 2 * DATA_W + $clog2(N_IN + 1)
) (
  input  logic                     clk,
  input  logic                     nRst,
  input  logic                     w_write,
  input  logic        [ADDR_W-1:0] w_addr,
  input  logic signed [DATA_W-1:0] w_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     busy
);

  localparam logic signed [ACC_W-1:0] c_sat_max = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] c_sat_min = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_OUT   = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic        [ADDR_W-1:0]  idx_q, idx_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0]   out_data_q, out_data_d;
  logic signed [DATA_W-1:0]  weight_q [N_IN];
  logic signed [DATA_W-1:0]  bias_q;

  logic signed [DATA_W-1:0]  w_sel;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   bias_ext;
  logic signed [ACC_W-1:0]   base;
  logic signed [ACC_W-1:0]   sum;
  logic signed [OUT_W-1:0]   sat_val;
  logic signed [OUT_W-1:0]   res;

  // Register file: writes land on the edge, so a same-cycle beat sees the old value.
  for (genvar i = 0; i < N_IN; i++) begin : g_weight
    always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
        weight_q[i] <= '0;
      end else if (w_write && (w_addr == ADDR_W'(i))) begin
        weight_q[i] <= w_data;
      end
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      bias_q <= '0;
    end else if (w_write && (w_addr == ADDR_W'(N_IN))) begin
      bias_q <= w_data;
    end
  end

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (idx_q == ADDR_W'(i)) w_sel = weight_q[i];
    end
  end

  assign prod     = in_data * w_sel;
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign bias_ext = {{(ACC_W-DATA_W){bias_q[DATA_W-1]}}, bias_q};
  // The bias seeds the sum on the first beat, so later bias writes miss this vector.
  assign base     = (idx_q == '0) ? bias_ext : acc_q;
  assign sum      = base + prod_ext;

  always_comb begin
    if (sum > c_sat_max) begin
      sat_val = c_sat_max[OUT_W-1:0];
    end else if (sum < c_sat_min) begin
      sat_val = c_sat_min[OUT_W-1:0];
    end else begin
      sat_val = sum[OUT_W-1:0];
    end
  end

`ifdef PERCEPT_RELU_EN
  assign res = sat_val[OUT_W-1] ? '0 : sat_val;
`else
  assign res = sat_val;
`endif

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (idx_q != '0) | out_valid_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      ST_ACCUM: begin
        if (in_valid) begin
          acc_d = sum;
          if (idx_q == ADDR_W'(N_IN - 1)) begin
            idx_d       = '0;
            state_d     = ST_OUT;
            out_valid_d = 1'b1;
            out_data_d  = res;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q     <= ST_ACCUM;
      idx_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_percept_mac.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_percept_mac : vector table and scoreboard bench for percept_mac.      |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module tb_percept_mac;

  logic              clk = 1'b0;
  logic              nRst;
  logic              w_write;
  logic [2:0]        w_addr;
  logic signed [7:0] w_data;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_data;
  logic              busy;

  percept_mac #(.N_IN(4), .DATA_W(8), .OUT_W(16)) dut (
    .clk      (clk),
    .nRst     (nRst),
    .w_write  (w_write),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][7:0] w;
    logic [7:0]      b;
    logic [3:0][7:0] x;
    logic [15:0]     exp;
  } vec_t;

  vec_t        vecs [9];
  logic [15:0] sb_q [$];
  logic [15:0] mon_exp;
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic vec_t mk(int w0, int w1, int w2, int w3, int b,
                              int x0, int x1, int x2, int x3, int e);
    vec_t v;
    v.w[0] = w0[7:0]; v.w[1] = w1[7:0]; v.w[2] = w2[7:0]; v.w[3] = w3[7:0];
    v.b    = b[7:0];
    v.x[0] = x0[7:0]; v.x[1] = x1[7:0]; v.x[2] = x2[7:0]; v.x[3] = x3[7:0];
    v.exp  = e[15:0];
    return v;
  endfunction

  function automatic logic [15:0] relu(logic [15:0] v);
`ifdef PERCEPT_RELU_EN
    return v[15] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (nRst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got 0x%0h, required no output", out_data);
      end else begin
        mon_exp = sb_q.pop_front();
        check("result", {16'h0, out_data}, {16'h0, mon_exp});
      end
    end
  end

  task automatic wr(int addr, int data);
    w_write = 1'b1;
    w_addr  = addr[2:0];
    w_data  = data[7:0];
    @(posedge clk); #1;
    w_write = 1'b0;
  endtask

  task automatic load(vec_t v);
    for (int i = 0; i < 4; i++) wr(i, int'(v.w[i]));
    wr(4, int'(v.b));
  endtask

  task automatic beat(logic [7:0] d);
    int k;
    in_valid = 1'b1;
    in_data  = d;
    k = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) begin
      n_tests++;
      n_fail++;
      $display("FAIL beat_timeout: in_ready 0x%0h, required 0x1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 'x;
  endtask

  task automatic send(vec_t v);
    for (int i = 0; i < 3; i++) beat(v.x[i]);
    sb_q.push_back(relu(v.exp));
    beat(v.x[3]);
  endtask

  task automatic wait_idle(string name);
    int k;
    k = 0;
    @(negedge clk);
    while (busy !== 1'b0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check(name, {31'h0, busy}, 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nRst = 1'b0; w_write = 1'b0; w_addr = '0; w_data = '0;
    in_valid = 1'b0; in_data = 'x; out_ready = 1'b1;

    vecs[0] = mk(8, 9, 10, 11, 0, 8, 8, 8, 8, 'h0130);
    vecs[1] = mk(-2, -2, -2, -2, 3, 5, 5, 5, 5, 'hFFDB);
    vecs[2] = mk(127, 127, 127, 127, -128, -128, -128, -128, -128, 'h8000);
    vecs[3] = mk(127, 127, 127, 127, 127, 127, 127, 127, 127, 'h7FFF);
    vecs[4] = mk(127, 127, 3, 1, 127, 127, 127, 127, 1, 'h7FFF);
    vecs[5] = mk(127, 127, 2, 0, 0, -128, -128, -128, 5, 'h8000);
    vecs[6] = mk(127, 127, 2, 0, -1, -128, -128, -128, 5, 'h8000);
    vecs[7] = mk(1, -1, 2, -2, -5, 10, 20, 30, 40, 'hFFDD);
    vecs[8] = mk(-128, -128, -128, -128, -128, -128, -128, -128, -128, 'h7FFF);

    #12;
    check("rst_in_ready",  {31'h0, in_ready},  32'h1);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_data",  {16'h0, out_data},  32'h0);
    check("rst_busy",      {31'h0, busy},      32'h0);
    #11 nRst = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 9; t++) begin
      load(vecs[t]);
      send(vecs[t]);
      check("latency_valid", {31'h0, out_valid}, 32'h1);
      check("out_in_ready",  {31'h0, in_ready},  32'h0);
      check("out_busy",      {31'h0, busy},      32'h1);
      wait_idle("idle_after_vec");
      check("ready_after_vec", {31'h0, in_ready}, 32'h1);
    end

    // Backpressure: result held while out_ready is low, pending beat refused.
    load(vecs[0]);
    out_ready = 1'b0;
    send(vecs[0]);
    in_valid = 1'b1;
    in_data  = 8'sd7;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_valid", {31'h0, out_valid}, 32'h1);
      check("stall_data",  {16'h0, out_data},  32'h130);
      check("stall_ready", {31'h0, in_ready},  32'h0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("drain_ready", {31'h0, in_ready}, 32'h0);
    @(posedge clk); #1;
    check("drained_valid", {31'h0, out_valid}, 32'h0);
    check("drained_ready", {31'h0, in_ready},  32'h1);
    check("drained_busy",  {31'h0, busy},      32'h0);
    send(mk(0, 0, 0, 0, 0, 1, 1, 1, 1, 38));
    wait_idle("idle_after_bp");

    // Weight write colliding with the beat that reads it.
    load(vecs[0]);
    beat(8'sd8);
    beat(8'sd8);
    in_valid = 1'b1; in_data = 8'sd8;
    w_write = 1'b1; w_addr = 3'd2; w_data = 8'sd0;
    @(posedge clk); #1;
    w_write = 1'b0; in_valid = 1'b0; in_data = 'x;
    sb_q.push_back(relu(16'd304));
    beat(8'sd8);
    wait_idle("idle_after_collide");
    send(mk(0, 0, 0, 0, 0, 8, 8, 8, 8, 224));
    wait_idle("idle_after_224");

    // Bias write after the first beat does not reach this vector.
    beat(8'sd8);
    wr(4, 100);
    beat(8'sd8);
    beat(8'sd8);
    sb_q.push_back(relu(16'd224));
    beat(8'sd8);
    wait_idle("idle_after_bias");

    // Out-of-range addresses are ignored; the new bias now applies.
    wr(7, 55);
    wr(5, 55);
    send(mk(0, 0, 0, 0, 0, 1, 1, 1, 1, 128));
    wait_idle("idle_after_oob");

    // Asynchronous reset in the middle of a vector.
    beat(8'sd5);
    beat(8'sd5);
    #2 nRst = 1'b0;
    #1;
    check("mid_rst_valid", {31'h0, out_valid}, 32'h0);
    check("mid_rst_busy",  {31'h0, busy},      32'h0);
    check("mid_rst_ready", {31'h0, in_ready},  32'h1);
    check("mid_rst_data",  {16'h0, out_data},  32'h0);
    #2 nRst = 1'b1;
    @(posedge clk); #1;
    send(mk(0, 0, 0, 0, 0, 5, 5, 5, 5, 0));
    wait_idle("idle_after_rst");

    check("scoreboard_empty", sb_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
